// File: rtl/buscador_instruccion_pkg.sv
// Shared MIPS fetch definitions: fetch FSM states, next-PC selector and opcode constants.
package mips_pkg;

    typedef enum logic [2:0] {
        INACTIVO = 3'd0,
        BUSCA    = 3'd1,
        EMITE    = 3'd2,
        EVALUA   = 3'd3,
        ALTO     = 3'd4
    } estado_buscador_t;

    typedef enum logic [1:0] {
        SEL_SECUENCIAL = 2'd0,
        SEL_RAMA       = 2'd1,
        SEL_SALTO      = 2'd2
    } sel_pc_t;

    localparam logic [5:0] OP_BEQ              = 6'b000100;
    localparam logic [5:0] OP_BNE              = 6'b000101;
    localparam logic [5:0] OP_J                = 6'b000010;
    localparam logic [5:0] OP_ALTO_POR_DEFECTO = 6'b111111;

    function automatic logic [5:0] opcode_de(input logic [31:0] palabra);
        return palabra[31:26];
    endfunction

endpackage

// File: rtl/buscador_instruccion_if.sv
// Instruction-memory request/ready bus between the fetch sequencer (master) and memory (slave).
interface buscador_instruccion_if;

    logic [31:0] mem_dir;
    logic        mem_lee;
    logic        mem_listo;
    logic [31:0] mem_dato;

    modport master (
        output mem_dir,
        output mem_lee,
        input  mem_listo,
        input  mem_dato
    );

    modport slave (
        input  mem_dir,
        input  mem_lee,
        output mem_listo,
        output mem_dato
    );

endinterface

// File: rtl/buscador_instruccion_sumador_pc.sv
// Combinational next-PC: sequential (pc+4), PC-relative branch, or pseudo-direct jump.
module sumador_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instruccion_i,
    input  sel_pc_t     sel_i,
    output logic [31:0] pc_siguiente_o
);

    logic [31:0] pc_mas4_s;
    logic [31:0] desplazamiento_s;
    logic        unused_opcode_s;

    assign pc_mas4_s        = pc_i + 32'd4;
    assign desplazamiento_s = {{14{instruccion_i[15]}}, instruccion_i[15:0], 2'b00};
    assign unused_opcode_s  = ^instruccion_i[31:26];

    // Select the next program counter; everything wraps modulo 2^32.
    always_comb begin
        pc_siguiente_o = pc_mas4_s;
        case (sel_i)
            SEL_SECUENCIAL: pc_siguiente_o = pc_mas4_s;
            SEL_RAMA:       pc_siguiente_o = pc_mas4_s + desplazamiento_s;
            SEL_SALTO:      pc_siguiente_o = {pc_mas4_s[31:28], instruccion_i[25:0], 2'b00};
            default:        pc_siguiente_o = pc_mas4_s;
        endcase
    end

endmodule

// File: rtl/buscador_instruccion.sv
// Instruction fetch sequencer: holds the PC, fetches over a request/ready bus, strobes each instruction.
// Branch/jump resolution (beq, bne, j) is built only when BUSCADOR_SALTOS_EN is defined.
module buscador_instruccion
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
    parameter logic [5:0]  OP_ALTO    = OP_ALTO_POR_DEFECTO
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          iniciar,
    buscador_instruccion_if.master        mem,
    output logic [31:0]                   instruccion,
    output logic                          inst_valida,
    input  logic                          zf,
    output logic [31:0]                   pc,
    output logic                          detenido
);

    estado_buscador_t estado_q;
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      instruccion_q;
    logic             mem_lee_q;
    logic             inst_valida_q;
    logic             detenido_q;
    sel_pc_t          sel_s;
    logic             es_rama_s;

`ifdef BUSCADOR_SALTOS_EN
    logic [5:0] opcode_s;
    logic       rama_tomada_s;

    assign opcode_s      = opcode_de(instruccion_q);
    assign es_rama_s     = (opcode_s == OP_BEQ) || (opcode_s == OP_BNE);
    assign rama_tomada_s = ((opcode_s == OP_BEQ) && zf) || ((opcode_s == OP_BNE) && !zf);

    // Jumps resolve in EMITE; branches wait for the zero flag in EVALUA.
    always_comb begin
        sel_s = SEL_SECUENCIAL;
        if ((estado_q == EMITE) && (opcode_s == OP_J)) begin
            sel_s = SEL_SALTO;
        end else if ((estado_q == EVALUA) && rama_tomada_s) begin
            sel_s = SEL_RAMA;
        end else begin
            sel_s = SEL_SECUENCIAL;
        end
    end
`else
    logic unused_zf_s;

    assign es_rama_s   = 1'b0;
    assign unused_zf_s = zf;
    assign sel_s       = SEL_SECUENCIAL;
`endif

    sumador_pc u_sumador_pc (
        .pc_i           (pc_q),
        .instruccion_i  (instruccion_q),
        .sel_i          (sel_s),
        .pc_siguiente_o (pc_d)
    );

    // Fetch FSM with registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q      <= INACTIVO;
            pc_q          <= PC_INICIAL;
            instruccion_q <= 32'h0000_0000;
            mem_lee_q     <= 1'b0;
            inst_valida_q <= 1'b0;
            detenido_q    <= 1'b0;
        end else begin
            case (estado_q)
                INACTIVO: begin
                    if (iniciar) begin
                        estado_q  <= BUSCA;
                        mem_lee_q <= 1'b1;
                    end
                end
                BUSCA: begin
                    if (mem.mem_listo) begin
                        instruccion_q <= mem.mem_dato;
                        mem_lee_q     <= 1'b0;
                        if (opcode_de(mem.mem_dato) == OP_ALTO) begin
                            estado_q   <= ALTO;
                            detenido_q <= 1'b1;
                        end else begin
                            estado_q      <= EMITE;
                            inst_valida_q <= 1'b1;
                        end
                    end
                end
                EMITE: begin
                    inst_valida_q <= 1'b0;
                    if (es_rama_s) begin
                        estado_q <= EVALUA;
                    end else begin
                        pc_q      <= pc_d;
                        estado_q  <= BUSCA;
                        mem_lee_q <= 1'b1;
                    end
                end
                EVALUA: begin
                    pc_q      <= pc_d;
                    estado_q  <= BUSCA;
                    mem_lee_q <= 1'b1;
                end
                ALTO: begin
                    detenido_q <= 1'b1;
                end
                default: begin
                    estado_q      <= INACTIVO;
                    mem_lee_q     <= 1'b0;
                    inst_valida_q <= 1'b0;
                    detenido_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_dir = pc_q;
    assign mem.mem_lee = mem_lee_q;
    assign instruccion = instruccion_q;
    assign inst_valida = inst_valida_q;
    assign pc          = pc_q;
    assign detenido    = detenido_q;

endmodule
